fix_msg_writer: RTL and testbench
=================================

Name: fix_msg_writer

Overview:
Upstream fill stage for the FIX message buffer RAM (single-port, 2**ADDR_WIDTH x 8, write on clk when we=1).
- Accepts a FIX byte stream over a valid/ready handshake.
- Writes each byte into the RAM at consecutive addresses starting from 0.
- Detects the checksum field "10=" and the SOH that ends it, and verifies the FIX checksum.
- Raises msg_done and holds the buffer until the downstream parser acknowledges.

Parameters:
ADDR_WIDTH, 6, RAM address width; buffer depth DEPTH = 2**ADDR_WIDTH bytes.
DATA_WIDTH, 8, byte width. Fixed at 8 because the stream is ASCII; other values are unsupported.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_data  in  DATA_WIDTH  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a byte
ram_data  out  DATA_WIDTH  RAM write data
ram_addr  out  ADDR_WIDTH  RAM address
ram_we  out  1  RAM write enable
msg_done  out  1  complete message held in RAM
msg_len  out  ADDR_WIDTH+1  bytes stored, including the final SOH
msg_chk_ok  out  1  received checksum matches the computed sum
msg_err  out  1  overflow occurred; message truncated
msg_ack  in  1  downstream releases the buffer

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to RECV; write pointer, byte count, running sum and tag matcher are cleared.
  - ram_we=0, ram_addr=0, ram_data=0, msg_done=0, msg_len=0, msg_chk_ok=0, msg_err=0.
  - in_ready=0 while rst=1.
  - Reset mid-message discards all partial state; the next byte goes to address 0.
- Accept rule: a byte is accepted when in_valid && in_ready.
  - in_ready = 1 in RECV, CHK and DROP; 0 in DONE.
- Write path latency:
  - Byte accepted at edge N drives ram_we=1, ram_addr=ptr, ram_data=byte during cycle N..N+1.
  - The RAM captures it at edge N+1.
  - ram_we=0 in every cycle without a prior accept. ptr increments per stored byte.
- Running sum: 8-bit, modulo 256, over every accepted byte.
  - sum_soh latches the running sum, including the SOH itself, whenever an SOH (0x01) is accepted.
- Tag matcher m (0..3), in RECV only:
  - SOH -> m=1.
  - m=1 & '1'(0x31) -> 2; m=2 & '0'(0x30) -> 3; m=3 & '='(0x3D) -> enter CHK.
  - Any other byte -> m=0.
  - Tag matching starts only after an SOH, so "110=" does not match.
- States:
  - RECV: store bytes, run the matcher.
  - CHK: store bytes. While the digit count is below 3, each ASCII digit accumulates value = value*10 + digit (10-bit); digit count is capped at 3. A non-digit byte other than SOH sets a bad flag. An SOH ends the field and goes to DONE, with msg_chk_ok = (digit count==3) && !bad && (value == sum_soh frozen at CHK entry).
  - DROP: entered when a byte arrives with count==DEPTH and the message has not ended. That byte and all later ones are not written. The matcher and CHK digit parsing keep running without writes until the terminating SOH, then go to DONE with msg_err=1, msg_chk_ok=0, msg_len=DEPTH.
  - DONE: msg_done=1 from the cycle after the terminating SOH is accepted (the same cycle as its ram_we), with msg_len, msg_chk_ok and msg_err stable. On msg_ack=1 in DONE: next cycle goes to RECV, msg_done/msg_len/msg_chk_ok/msg_err return to 0, and ptr, count, sum and m clear. msg_ack outside DONE is ignored.
- Boundary conditions:
  - A terminating SOH arriving as byte DEPTH (count==DEPTH-1) is stored; msg_err=0.
  - Accept and ack never coincide, because in_ready=0 in DONE.
  - in_valid gaps are allowed in every state; no state advances without an accept.

Test Plan:
1. Send "8=A\x0110=183\x01" (11 bytes), msg_ack low -> 11 ram_we pulses at addr 0..10; RAM[0]=0x38, RAM[10]=0x01; msg_done=1, msg_len=11, msg_chk_ok=1, msg_err=0.
2. Same message with "10=184" -> msg_done=1, msg_len=11, msg_chk_ok=0, msg_err=0.
3. "8=A\x01110=5\x0110=188\x01" (17 bytes) -> "110=" is not treated as checksum; msg_len=17, msg_chk_ok=1.
4. After test 1, hold in_valid=1 and msg_ack=0 for 5 cycles -> in_ready=0 and no ram_we. Pulse msg_ack -> msg_done=0 next cycle; next message's first byte is written at addr 0.
5. 70-byte message with "10=" first appearing at byte 66 -> exactly 64 ram_we pulses (addr 0..63); msg_done with msg_len=64, msg_err=1, msg_chk_ok=0.
6. Assert rst for 1 cycle after 5 bytes of a message, then send test 1's message -> ram_addr restarts at 0; msg_len=11, msg_chk_ok=1.

Source files
------------

// File: rtl/fix_msg_writer.sv
`default_nettype none
// ============================================================================
// Module   : fix_msg_writer
// Purpose  : Fills the FIX message RAM from a byte stream, locates the
//            "10=" trailer and verifies the FIX checksum before handing off.
// Revision : 1.0 - initial release
// ============================================================================
module fix_msg_writer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  msg_done,
    output logic [ADDR_WIDTH:0]   msg_len,
    output logic                  msg_chk_ok,
    output logic                  msg_err,
    input  logic                  msg_ack
);

    localparam logic [ADDR_WIDTH:0]   c_DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_SOH   = 8'h01;
    localparam logic [DATA_WIDTH-1:0] c_ONE   = 8'h31;
    localparam logic [DATA_WIDTH-1:0] c_ZERO  = 8'h30;
    localparam logic [DATA_WIDTH-1:0] c_EQ    = 8'h3D;

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_CHK  = 2'd1,
        ST_DROP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_sum_soh;
    logic [DATA_WIDTH-1:0] r_chk_ref;
    logic [1:0]            r_match;
    logic                  r_in_chk;
    logic [9:0]            r_value;
    logic [1:0]            r_digits;
    logic                  r_bad;

    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_data;
    logic                  r_msg_done;
    logic [ADDR_WIDTH:0]   r_msg_len;
    logic                  r_msg_chk_ok;
    logic                  r_msg_err;

    logic                  w_accept;
    logic                  w_store;
    logic                  w_is_digit;
    logic [DATA_WIDTH-1:0] w_sum_next;
    logic [9:0]            w_value_next;
    logic                  w_sum_match;

    assign in_ready     = !rst && (r_state != ST_DONE);
    assign w_accept     = in_valid && in_ready;
    // Bytes past the buffer end, or anything once in DROP, are parsed but not written.
    assign w_store      = (r_state != ST_DROP) && (r_count < c_DEPTH);
    assign w_is_digit   = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign w_sum_next   = r_sum + in_data;
    assign w_value_next = r_value * 10'd10 + {2'b00, in_data} - 10'd48;
    assign w_sum_match  = (r_value == {2'b00, r_chk_ref});

    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_data   = r_ram_data;
    assign msg_done   = r_msg_done;
    assign msg_len    = r_msg_len;
    assign msg_chk_ok = r_msg_chk_ok;
    assign msg_err    = r_msg_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RECV;
            r_ptr        <= '0;
            r_count      <= '0;
            r_sum        <= '0;
            r_sum_soh    <= '0;
            r_chk_ref    <= '0;
            r_match      <= 2'd0;
            r_in_chk     <= 1'b0;
            r_value      <= '0;
            r_digits     <= 2'd0;
            r_bad        <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_msg_done   <= 1'b0;
            r_msg_len    <= '0;
            r_msg_chk_ok <= 1'b0;
            r_msg_err    <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            case (r_state)
                ST_RECV, ST_CHK, ST_DROP: begin
                    if (w_accept) begin
                        r_sum <= w_sum_next;
                        if (w_store) begin
                            r_ram_we   <= 1'b1;
                            r_ram_addr <= r_ptr;
                            r_ram_data <= in_data;
                            r_ptr      <= r_ptr + 1'b1;
                            r_count    <= r_count + 1'b1;
                        end else begin
                            r_state <= ST_DROP;
                        end

                        if (!r_in_chk) begin
                            // Tag matcher: only "<SOH>10=" opens the checksum field.
                            if (in_data == c_SOH) begin
                                r_match   <= 2'd1;
                                r_sum_soh <= w_sum_next;
                            end else if (r_match == 2'd1 && in_data == c_ONE) begin
                                r_match <= 2'd2;
                            end else if (r_match == 2'd2 && in_data == c_ZERO) begin
                                r_match <= 2'd3;
                            end else if (r_match == 2'd3 && in_data == c_EQ) begin
                                r_match   <= 2'd0;
                                r_in_chk  <= 1'b1;
                                r_chk_ref <= r_sum_soh;
                                r_value   <= '0;
                                r_digits  <= 2'd0;
                                r_bad     <= 1'b0;
                                if (w_store) begin
                                    r_state <= ST_CHK;
                                end
                            end else begin
                                r_match <= 2'd0;
                            end
                        end else begin
                            if (in_data == c_SOH) begin
                                r_sum_soh    <= w_sum_next;
                                r_state      <= ST_DONE;
                                r_msg_done   <= 1'b1;
                                r_msg_err    <= !w_store;
                                r_msg_len    <= w_store ? (r_count + 1'b1) : r_count;
                                r_msg_chk_ok <= w_store && (r_digits == 2'd3) && !r_bad
                                                && w_sum_match;
                            end else if (w_is_digit) begin
                                // Digits past the third are ignored rather than flagged.
                                if (r_digits != 2'd3) begin
                                    r_value  <= w_value_next;
                                    r_digits <= r_digits + 1'b1;
                                end
                            end else begin
                                r_bad <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (msg_ack) begin
                        r_state      <= ST_RECV;
                        r_ptr        <= '0;
                        r_count      <= '0;
                        r_sum        <= '0;
                        r_sum_soh    <= '0;
                        r_match      <= 2'd0;
                        r_in_chk     <= 1'b0;
                        r_value      <= '0;
                        r_digits     <= 2'd0;
                        r_bad        <= 1'b0;
                        r_msg_done   <= 1'b0;
                        r_msg_len    <= '0;
                        r_msg_chk_ok <= 1'b0;
                        r_msg_err    <= 1'b0;
                    end
                end
                default: r_state <= ST_RECV;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fix_msg_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fix_msg_writer
// Purpose  : Randomized self-checking bench for fix_msg_writer against a
//            string-level model of FIX trailer detection and checksum rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fix_msg_writer;

    localparam int AW    = 6;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          msg_done;
    logic [AW:0]   msg_len;
    logic          msg_chk_ok;
    logic          msg_err;
    logic          msg_ack;

    always #5 clk = ~clk;

    fix_msg_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ram_data   (ram_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .msg_done   (msg_done),
        .msg_len    (msg_len),
        .msg_chk_ok (msg_chk_ok),
        .msg_err    (msg_err),
        .msg_ack    (msg_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]    msg_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [7:0]    wr_data_q[$];

    int exp_len;
    int exp_writes;
    bit exp_ok;
    bit exp_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Write-port monitor: every RAM write request is recorded for later comparison.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_data);
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic push_num3(input int v);
        msg_q.push_back(8'(48 + v / 100));
        msg_q.push_back(8'(48 + (v / 10) % 10));
        msg_q.push_back(8'(48 + v % 10));
    endtask

    // Reference: find the first "<SOH>10=", the SOH that closes it, and judge the field.
    task automatic model();
        int t;
        int j;
        int s;
        int val;
        int nd;
        bit bad;
        t = -1;
        j = -1;
        for (int i = 0; i + 3 < msg_q.size(); i++) begin
            if (msg_q[i] == 8'h01 && msg_q[i+1] == 8'h31 && msg_q[i+2] == 8'h30
                && msg_q[i+3] == 8'h3D) begin
                t = i;
                break;
            end
        end
        if (t >= 0) begin
            for (int k = t + 4; k < msg_q.size(); k++) begin
                if (msg_q[k] == 8'h01) begin
                    j = k;
                    break;
                end
            end
        end
        if (j < 0) begin
            $display("FAIL model_terminator: got %0d expected %0d", j, 0);
            $fatal(1, "stimulus without trailer");
        end
        while (msg_q.size() > j + 1) void'(msg_q.pop_back());
        s = 0;
        for (int k = 0; k <= t; k++) s += msg_q[k];
        s = s % 256;
        val = 0;
        nd  = 0;
        bad = 0;
        for (int k = t + 4; k < j; k++) begin
            if (msg_q[k] >= 8'h30 && msg_q[k] <= 8'h39) begin
                if (nd < 3) begin
                    val = val * 10 + (msg_q[k] - 48);
                    nd++;
                end
            end else begin
                bad = 1;
            end
        end
        if (j + 1 > DEPTH) begin
            exp_len    = DEPTH;
            exp_writes = DEPTH;
            exp_err    = 1;
            exp_ok     = 0;
        end else begin
            exp_len    = j + 1;
            exp_writes = j + 1;
            exp_err    = 0;
            exp_ok     = (nd == 3) && !bad && (val == s);
        end
    endtask

    task automatic send_bytes(input int n);
        int idx;
        int cyc;
        bit take;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 2000) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = msg_q[idx];
            end
            #1;
            take = in_valid && in_ready;
            @(posedge clk);
            if (take) idx++;
            cyc++;
        end
        if (idx < n) check_val("send_timeout", 32'(idx), 32'(n));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic clear_wr();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic run_msg(input string tag);
        model();
        send_bytes(msg_q.size());
        // send_bytes returns at the negedge just after the final accept
        check_val({tag, "_done"},  32'(msg_done),   32'd1);
        check_val({tag, "_len"},   32'(msg_len),    32'(exp_len));
        check_val({tag, "_chkok"}, 32'(msg_chk_ok), 32'(exp_ok));
        check_val({tag, "_err"},   32'(msg_err),    32'(exp_err));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h41;
            #1;
            check_val({tag, "_ready_in_done"}, 32'(in_ready), 32'd0);
            check_val({tag, "_done_hold"},     32'(msg_done), 32'd1);
        end
        check_val({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(exp_writes));
        for (int k = 0; k < wr_addr_q.size() && k < exp_writes; k++) begin
            check_val({tag, "_waddr"}, 32'(wr_addr_q[k]), 32'(k));
            check_val({tag, "_wdata"}, 32'(wr_data_q[k]), 32'(msg_q[k]));
        end
        @(negedge clk);
        in_valid = 1'b0;
        msg_ack  = 1'b1;
        @(negedge clk);
        msg_ack = 1'b0;
        check_val({tag, "_done_clr"}, 32'(msg_done), 32'd0);
        check_val({tag, "_len_clr"},  32'(msg_len),  32'd0);
        check_val({tag, "_err_clr"},  32'(msg_err),  32'd0);
        clear_wr();
    endtask

    task automatic build_basic(input string chk);
        msg_q.delete();
        push_str("8=A");
        msg_q.push_back(8'h01);
        push_str({"10=", chk});
        msg_q.push_back(8'h01);
    endtask

    task automatic build_random();
        int blen;
        int s;
        int mode;
        logic [7:0] b;
        msg_q.delete();
        blen = $urandom_range(0, 75);
        s = 0;
        for (int i = 0; i < blen; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 8'h01;
                1:       b = 8'h31;
                2:       b = 8'h30;
                3:       b = 8'h3D;
                default: b = 8'(8'h41 + $urandom_range(0, 25));
            endcase
            msg_q.push_back(b);
            s += b;
        end
        msg_q.push_back(8'h01);
        s = (s + 1) % 256;
        push_str("10=");
        mode = $urandom_range(0, 4);
        case (mode)
            0, 1:    push_num3(s);
            2:       push_num3((s + 1 + $urandom_range(0, 200)) % 256);
            3:       begin msg_q.push_back(8'(48 + s / 100)); msg_q.push_back(8'(48 + s % 10)); end
            default: begin push_num3(s); msg_q[msg_q.size()-2] = 8'h58; end
        endcase
        msg_q.push_back(8'h01);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        msg_ack  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_ready",  32'(in_ready),   32'd0);
        check_val("rst_we",     32'(ram_we),     32'd0);
        check_val("rst_addr",   32'(ram_addr),   32'd0);
        check_val("rst_data",   32'(ram_data),   32'd0);
        check_val("rst_done",   32'(msg_done),   32'd0);
        check_val("rst_len",    32'(msg_len),    32'd0);
        check_val("rst_chkok",  32'(msg_chk_ok), 32'd0);
        check_val("rst_err",    32'(msg_err),    32'd0);
        rst = 1'b0;
        #1;
        check_val("ready_after_rst", 32'(in_ready), 32'd1);
        clear_wr();

        build_basic("183");
        run_msg("t1");
        build_basic("184");
        run_msg("t2");

        msg_q.delete();
        push_str("8=A");
        msg_q.push_back(8'h01);
        push_str("110=5");
        msg_q.push_back(8'h01);
        push_str("10=188");
        msg_q.push_back(8'h01);
        run_msg("t3");

        // 70 bytes; the trailer tag starts past the end of the buffer
        msg_q.delete();
        push_str("8=FIX");
        msg_q.push_back(8'h01);
        while (msg_q.size() < 64) msg_q.push_back(8'h78);
        msg_q.push_back(8'h01);
        push_str("10=7");
        msg_q.push_back(8'h01);
        run_msg("t5");

        build_basic("183");
        send_bytes(5);
        rst = 1'b1;
        #1;
        check_val("midrst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_we",   32'(ram_we),   32'd0);
        check_val("midrst_addr", 32'(ram_addr), 32'd0);
        check_val("midrst_done", 32'(msg_done), 32'd0);
        clear_wr();
        run_msg("t6");

        for (int r = 0; r < 40; r++) begin
            build_random();
            run_msg("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
